timer_apb_slave: RTL and testbench

//  APB3 slave that terminates CPU-side APB transfers and hosts the 64-bit system timer.
//  It holds the register file, prescaler, counter, compare logic and interrupt status.
//  It sits directly downstream of the APB master and drives tim_int to the interrupt handler.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_apb_slave_if.sv | 25 ++
 rtl/timer_counter.sv | 54 +++++
 rtl/timer_apb_slave.sv | 158 +++++++++++++++
 tb/tb_timer_apb_slave.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, field positions and APB state type for the system timer
package timer_pkg;

  localparam logic [11:0] TCR_OFS   = 12'h000;
  localparam logic [11:0] TDR0_OFS  = 12'h004;
  localparam logic [11:0] TDR1_OFS  = 12'h008;
  localparam logic [11:0] TCMP0_OFS = 12'h00C;
  localparam logic [11:0] TCMP1_OFS = 12'h010;
  localparam logic [11:0] TIER_OFS  = 12'h014;
  localparam logic [11:0] TISR_OFS  = 12'h018;

  localparam int TCR_EN_BIT     = 0;
  localparam int TCR_DIV_EN_BIT = 1;
  localparam int TCR_DIV_LSB    = 8;
  localparam int TCR_DIV_MSB    = 11;
  localparam int TIER_EN_BIT    = 0;
  localparam int TISR_ST_BIT    = 0;

  localparam int MAX_DIV = 8;
  localparam int PRESC_W = 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  // Terminal prescaler value for a divide-by-2^div_val tick.
  function automatic logic [PRESC_W-1:0] div_limit(input logic [3:0] div_val);
    logic [PRESC_W:0] one;
    one = (PRESC_W + 1)'(1);
    return PRESC_W'((one << div_val) - one);
  endfunction

endpackage

// File: rtl/timer_apb_slave_if.sv
// rtl/timer_apb_slave_if.sv - APB3 bus bundle between the CPU-side master and the timer slave
interface timer_apb_slave_if #(
  parameter int ADDR_W = 32
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - prescaler, 64-bit free-running counter with write override, compare match
module timer_counter
  import timer_pkg::*;
(
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        div_clr,
  input  logic        tdr0_we,
  input  logic        tdr1_we,
  input  logic [31:0] wdata,
  input  logic [63:0] cmp,
  output logic [63:0] count,
  output logic        match
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [63:0]        count_q, count_d;
  logic               tick;
  logic               inc;

  always_comb begin
    tick    = div_en && (presc_q == div_limit(div_val));
    inc     = timer_en && (!div_en || tick);
    presc_d = presc_q + PRESC_W'(1);
    // Prescaler only runs while dividing; any disable or divider change restarts the phase.
    if (!timer_en || !div_en || div_clr || tick) begin
      presc_d = '0;
    end
    count_d = inc ? count_q + 64'd1 : count_q;
    if (tdr0_we) begin
      count_d = {count_q[63:32], wdata};
    end
    if (tdr1_we) begin
      count_d = {wdata, count_q[31:0]};
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign match = (count_q == cmp);

endmodule

// File: rtl/timer_apb_slave.sv
// rtl/timer_apb_slave.sv - APB3 slave hosting the 64-bit system timer register file and interrupt
module timer_apb_slave
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic             pclk,
  input  logic             preset_n,
  timer_apb_slave_if.slave apb,
  output logic             tim_int
);

  apb_state_t  state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        timer_en_q, timer_en_d;
  logic        div_en_q, div_en_d;
  logic [3:0]  div_val_q, div_val_d;
  logic [63:0] cmp_q, cmp_d;
  logic        int_en_q, int_en_d;
  logic        int_st_q, int_st_d;

  logic [11:0] offset;
  logic [31:0] wdata;
  logic [31:0] rd_val;
  logic [63:0] count;
  logic        mapped, addr_err, tcr_bad, err;
  logic        pready, wr_en, tcr_we;
  logic        div_clr, tdr0_we, tdr1_we, match;

  always_comb begin
    offset = apb.paddr[11:0];
    wdata  = apb.pwdata;
    mapped = 1'b0;
    case (offset)
      TCR_OFS, TDR0_OFS, TDR1_OFS, TCMP0_OFS, TCMP1_OFS, TIER_OFS, TISR_OFS: mapped = 1'b1;
      default: mapped = 1'b0;
    endcase
    addr_err = (|apb.paddr[ADDR_W-1:12]) || (offset[1:0] != 2'b00) || !mapped;
    tcr_bad  = apb.pwrite && (offset == TCR_OFS)
            && (wdata[TCR_DIV_MSB:TCR_DIV_LSB] > 4'(MAX_DIV));
    err      = addr_err || tcr_bad;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pready  = 1'b0;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (apb.psel && !apb.penable) state_d = SETUP;
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (wait_q == 4'(WAIT_CYCLES)) begin
          if (apb.penable) begin
            pready  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      TCR_OFS: begin
        rd_val[TCR_EN_BIT]                  = timer_en_q;
        rd_val[TCR_DIV_EN_BIT]              = div_en_q;
        rd_val[TCR_DIV_MSB:TCR_DIV_LSB]     = div_val_q;
      end
      TDR0_OFS:  rd_val = count[31:0];
      TDR1_OFS:  rd_val = count[63:32];
      TCMP0_OFS: rd_val = cmp_q[31:0];
      TCMP1_OFS: rd_val = cmp_q[63:32];
      TIER_OFS:  rd_val[TIER_EN_BIT] = int_en_q;
      TISR_OFS:  rd_val[TISR_ST_BIT] = int_st_q;
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    wr_en      = pready && apb.pwrite && !err;
    tcr_we     = wr_en && (offset == TCR_OFS);
    tdr0_we    = wr_en && (offset == TDR0_OFS);
    tdr1_we    = wr_en && (offset == TDR1_OFS);
    div_clr    = tcr_we && (wdata[TCR_DIV_MSB:TCR_DIV_LSB] != div_val_q);
    timer_en_d = timer_en_q;
    div_en_d   = div_en_q;
    div_val_d  = div_val_q;
    cmp_d      = cmp_q;
    int_en_d   = int_en_q;
    if (tcr_we) begin
      timer_en_d = wdata[TCR_EN_BIT];
      div_en_d   = wdata[TCR_DIV_EN_BIT];
      div_val_d  = wdata[TCR_DIV_MSB:TCR_DIV_LSB];
    end
    if (wr_en && (offset == TCMP0_OFS)) cmp_d[31:0]  = wdata;
    if (wr_en && (offset == TCMP1_OFS)) cmp_d[63:32] = wdata;
    if (wr_en && (offset == TIER_OFS))  int_en_d     = wdata[TIER_EN_BIT];
    // A match in the same cycle as a write-1-to-clear keeps the status set.
    int_st_d = match
            || (int_st_q && !(wr_en && (offset == TISR_OFS) && wdata[TISR_ST_BIT]));
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      timer_en_q <= 1'b0;
      div_en_q   <= 1'b0;
      div_val_q  <= '0;
      cmp_q      <= '1;
      int_en_q   <= 1'b0;
      int_st_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      timer_en_q <= timer_en_d;
      div_en_q   <= div_en_d;
      div_val_q  <= div_val_d;
      cmp_q      <= cmp_d;
      int_en_q   <= int_en_d;
      int_st_q   <= int_st_d;
    end
  end

  timer_counter u_counter (
    .pclk     (pclk),
    .preset_n (preset_n),
    .timer_en (timer_en_q),
    .div_en   (div_en_q),
    .div_val  (div_val_q),
    .div_clr  (div_clr),
    .tdr0_we  (tdr0_we),
    .tdr1_we  (tdr1_we),
    .wdata    (wdata),
    .cmp      (cmp_q),
    .count    (count),
    .match    (match)
  );

  assign apb.pready  = pready;
  assign apb.pslverr = pready && err;
  assign apb.prdata  = (pready && !err) ? rd_val : '0;
  assign tim_int     = int_st_q && int_en_q;

endmodule

// File: tb/tb_timer_apb_slave.sv
// tb/tb_timer_apb_slave.sv - self-checking bench for timer_apb_slave with a behavioural timer model
module tb_timer_apb_slave;

  localparam int WAIT = 2;

  logic pclk;
  logic preset_n;
  logic tim_int;

  timer_apb_slave_if #(.ADDR_W(32)) bus ();

  timer_apb_slave #(.WAIT_CYCLES(WAIT), .ADDR_W(32)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .apb      (bus),
    .tim_int  (tim_int)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural model of the programmer-visible timer state.
  logic [63:0] m_cnt, m_cmp;
  int          m_presc;
  logic        m_en, m_div_en, m_int_en, m_int_st;
  logic [3:0]  m_dv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = '0; m_cmp = '1; m_presc = 0;
    m_en = 1'b0; m_div_en = 1'b0; m_dv = '0;
    m_int_en = 1'b0; m_int_st = 1'b0;
  endfunction

  function automatic bit m_err(input logic [31:0] a, input bit we, input logic [31:0] d);
    if (a[31:12] != 20'd0 || a[1:0] != 2'd0 || a[11:0] > 12'h018) return 1'b1;
    if (we && a[11:0] == 12'h000 && d[11:8] > 4'd8) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[11:0])
      12'h000: return {20'd0, m_dv, 6'd0, m_div_en, m_en};
      12'h004: return m_cnt[31:0];
      12'h008: return m_cnt[63:32];
      12'h00C: return m_cmp[31:0];
      12'h010: return m_cmp[63:32];
      12'h014: return {31'd0, m_int_en};
      12'h018: return {31'd0, m_int_st};
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge: counting rules, then any committing write.
  function automatic void model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit          match, w;
    logic [63:0] nxt;
    match = (m_cnt == m_cmp);
    nxt   = m_cnt;
    if (m_en && !m_div_en) begin
      nxt = m_cnt + 64'd1;
      m_presc = 0;
    end else if (m_en && m_div_en) begin
      if (m_presc == (1 << m_dv) - 1) begin
        nxt = m_cnt + 64'd1;
        m_presc = 0;
      end else begin
        m_presc = m_presc + 1;
      end
    end else begin
      m_presc = 0;
    end
    w = we && !m_err(a, 1'b1, d);
    m_int_st = match || (m_int_st && !(w && a[11:0] == 12'h018 && d[0]));
    if (w) begin
      case (a[11:0])
        12'h000: begin
          if (d[11:8] != m_dv) m_presc = 0;
          m_en = d[0]; m_div_en = d[1]; m_dv = d[11:8];
        end
        12'h004: nxt = {m_cnt[63:32], d};
        12'h008: nxt = {d, m_cnt[31:0]};
        12'h00C: m_cmp[31:0] = d;
        12'h010: m_cmp[63:32] = d;
        12'h014: m_int_en = d[0];
        default: ;
      endcase
    end
    m_cnt = nxt;
  endfunction

  task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge pclk);
    model_step(we, a, d);
    cyc++;
    @(negedge pclk);
    chk("tim_int", 64'(tim_int), 64'(m_int_st & m_int_en));
  endtask

  task automatic apb(input bit we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    int          k;
    bit          exp_err;
    logic [31:0] exp_rd;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = we; bus.paddr = a; bus.pwdata = d;
    cycle(1'b0, 32'd0, 32'd0);
    bus.penable = 1'b1;
    k = 0;
    #1;
    while (bus.pready !== 1'b1 && k < 20) begin
      chk("pready_early", 64'(bus.pready), 64'd0);
      cycle(1'b0, 32'd0, 32'd0);
      k++;
      #1;
    end
    chk("pready_lat", 64'(k), 64'(WAIT + 1));
    exp_err = m_err(a, we, d);
    exp_rd  = exp_err ? 32'd0 : m_read(a);
    rd = bus.prdata;
    er = bus.pslverr;
    chk("pslverr", 64'(er), 64'(exp_err));
    chk("prdata", 64'(rd), 64'(exp_rd));
    cycle(we, a, d);
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    chk("pready_once", 64'(bus.pready), 64'd0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[17];

  initial begin
    logic [31:0] rd, r1, r2;
    logic        er;
    int          c1, c2, n;
    logic [31:0] a, d;
    bit          we;
    int          sel;

    vt[0]  = '{1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_0000};
    vt[1]  = '{1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h0000_0000};
    vt[2]  = '{1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h0000_0000};
    vt[3]  = '{1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'hFFFF_FFFF};
    vt[4]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hFFFF_FFFF};
    vt[5]  = '{1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0000_0000};
    vt[6]  = '{1'b0, 32'h0000_0018, 32'h0, 1'b0, 32'h0000_0000};
    vt[7]  = '{1'b0, 32'h0000_001C, 32'h0, 1'b1, 32'h0000_0000};
    vt[8]  = '{1'b0, 32'h0000_0006, 32'h0, 1'b1, 32'h0000_0000};
    vt[9]  = '{1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_0000};
    vt[10] = '{1'b1, 32'h0000_000C, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF};
    vt[11] = '{1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'h1234_5678};
    vt[12] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vt[13] = '{1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0000_0001};
    vt[14] = '{1'b1, 32'h0000_0000, 32'h0000_0900, 1'b1, 32'h0000_0000};
    vt[15] = '{1'b1, 32'h0000_101C, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    vt[16] = '{1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0000_0000};

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    preset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    chk("rst_pready", 64'(bus.pready), 64'd0);
    chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
    chk("rst_prdata", 64'(bus.prdata), 64'd0);
    chk("rst_tim_int", 64'(tim_int), 64'd0);
    preset_n = 1'b1;
    cycle(1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 17; i++) begin
      apb(vt[i].we, vt[i].addr, vt[i].wdata, rd, er);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(vt[i].exp_rd));
    end

    // Undivided counting: counter advances by exactly the elapsed pclk count.
    apb(1'b1, 32'h0, 32'h0000_0001, rd, er);
    apb(1'b0, 32'h4, 32'h0, r1, er); c1 = cyc;
    apb(1'b0, 32'h4, 32'h0, r2, er); c2 = cyc;
    chk("cnt_every_clk", 64'(r2 - r1), 64'(c2 - c1));

    // Divide by 4, then a rejected div_val of 9.
    apb(1'b1, 32'h0, 32'h0000_0203, rd, er);
    repeat (11) cycle(1'b0, 32'd0, 32'd0);
    apb(1'b0, 32'h4, 32'h0, r1, er); c1 = cyc;
    repeat (3) cycle(1'b0, 32'd0, 32'd0);
    apb(1'b0, 32'h4, 32'h0, r2, er); c2 = cyc;
    chk("div4_rate", 64'(r2 - r1), 64'((c2 - c1) / 4));
    apb(1'b1, 32'h0, 32'h0000_0903, rd, er);
    chk("div9_rej", 64'(er), 64'd1);
    apb(1'b0, 32'h0, 32'h0, rd, er);
    chk("tcr_kept", 64'(rd), 64'h203);

    // 64-bit wrap.
    apb(1'b1, 32'h0, 32'h0, rd, er);
    apb(1'b1, 32'h8, 32'hFFFF_FFFF, rd, er);
    apb(1'b1, 32'h4, 32'hFFFF_FFFE, rd, er);
    apb(1'b1, 32'h0, 32'h1, rd, er);
    apb(1'b0, 32'h8, 32'h0, rd, er);
    chk("wrap_hi", 64'(rd), 64'd0);
    apb(1'b0, 32'h4, 32'h0, rd, er);

    // Compare interrupt, clear, and set-beats-clear.
    apb(1'b1, 32'h0, 32'h0, rd, er);
    apb(1'b1, 32'h4, 32'h0, rd, er);
    apb(1'b1, 32'h8, 32'h0, rd, er);
    apb(1'b1, 32'h10, 32'h0, rd, er);
    apb(1'b1, 32'hC, 32'h10, rd, er);
    apb(1'b1, 32'h18, 32'h1, rd, er);
    apb(1'b1, 32'h14, 32'h1, rd, er);
    chk("int_idle", 64'(tim_int), 64'd0);
    apb(1'b1, 32'h0, 32'h1, rd, er);
    n = 0;
    while (tim_int !== 1'b1 && n < 60) begin
      cycle(1'b0, 32'd0, 32'd0);
      n++;
    end
    chk("tim_int_rise", 64'(tim_int), 64'd1);
    apb(1'b1, 32'h18, 32'h1, rd, er);
    chk("w1c_clear", 64'(tim_int), 64'd0);
    apb(1'b1, 32'h4, 32'h0000_000C, rd, er);
    apb(1'b1, 32'h18, 32'h1, rd, er);
    chk("set_beats_w1c", 64'(tim_int), 64'd1);

    // Reset in the middle of an ACCESS phase.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'hC; bus.pwdata = 32'h0;
    cycle(1'b0, 32'd0, 32'd0);
    bus.penable = 1'b1;
    cycle(1'b0, 32'd0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0);
    #1 preset_n = 1'b0;
    #1;
    chk("arst_pready", 64'(bus.pready), 64'd0);
    chk("arst_pslverr", 64'(bus.pslverr), 64'd0);
    chk("arst_prdata", 64'(bus.prdata), 64'd0);
    chk("arst_tim_int", 64'(tim_int), 64'd0);
    repeat (2) @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    preset_n = 1'b1;
    model_reset();
    apb(1'b0, 32'hC, 32'h0, rd, er);
    chk("arst_tcmp0", 64'(rd), 64'hFFFF_FFFF);
    apb(1'b0, 32'h10, 32'h0, rd, er);
    chk("arst_tcmp1", 64'(rd), 64'hFFFF_FFFF);
    apb(1'b0, 32'h0, 32'h0, rd, er);
    chk("arst_tcr", 64'(rd), 64'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 120; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel <= 6) a = 32'(sel * 4);
      else if (sel == 7) a = 32'h1C;
      else if (sel == 8) a = 32'h4 | 32'($urandom_range(1, 3));
      else a = 32'h0001_0000 | 32'($urandom_range(0, 6) * 4);
      if (a == 32'h0 && $urandom_range(0, 1) == 1) d[11:8] = 4'($urandom_range(0, 3));
      apb(we, a, d, rd, er);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 32'd0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
